// File: rtl/if_fetch_queue.sv
// Instruction-fetch front end: one-outstanding variable-latency memory requests feeding
// a DEPTH-entry {pc, inst} prefetch queue that ID drains through a valid/ready handshake.
module if_fetch_queue #(
  parameter int                ADDR_W   = 32,
  parameter int                INST_W   = 32,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              rom_ce_o,
  output logic [ADDR_W-1:0] rom_addr_o,
  input  logic              rom_ack_i,
  input  logic [INST_W-1:0] rom_data_i,
  input  logic              branch_i,
  input  logic [ADDR_W-1:0] branch_addr_i,
  output logic              id_valid_o,
  output logic [ADDR_W-1:0] id_pc_o,
  output logic [INST_W-1:0] id_inst_o,
  input  logic              id_ready_i
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DROP = 2'd2
  } state_t;

  state_t            state_r;
  logic [ADDR_W-1:0] next_pc_r;
  logic [ADDR_W-1:0] req_addr_r;
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [PTR_W-1:0]  wr_ptr_r;
  logic [CNT_W-1:0]  count_r;
  logic [ADDR_W-1:0] pc_q_r   [DEPTH];
  logic [INST_W-1:0] inst_q_r [DEPTH];

  logic              push_s;
  logic              pop_s;
  logic [CNT_W-1:0]  count_next_s;
  logic              space_s;
  logic [ADDR_W-1:0] target_s;

  // Handshake decode; a redirect cancels both push and pop in its cycle.
  always_comb begin
    push_s       = (state_r == REQ) && rom_ack_i && !branch_i;
    pop_s        = (count_r != '0) && id_ready_i && !branch_i;
    count_next_s = count_r + CNT_W'(push_s) - CNT_W'(pop_s);
    space_s      = count_next_s < CNT_W'(DEPTH);
    target_s     = branch_addr_i & ~ADDR_W'(3);
  end

  // Queue storage, pointers and occupancy; a redirect flushes by aligning rd to wr.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_r <= '0;
      wr_ptr_r <= '0;
      count_r  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_q_r[i]   <= '0;
        inst_q_r[i] <= '0;
      end
    end else if (branch_i) begin
      rd_ptr_r <= wr_ptr_r;
      count_r  <= '0;
    end else begin
      if (push_s) begin
        pc_q_r[wr_ptr_r]   <= req_addr_r;
        inst_q_r[wr_ptr_r] <= rom_data_i;
        wr_ptr_r           <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      count_r <= count_next_s;
    end
  end

  // Request sequencer; DROP waits out an abandoned request whose data must be discarded.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      next_pc_r  <= RESET_PC;
      req_addr_r <= RESET_PC;
    end else begin
      case (state_r)
        IDLE: begin
          if (branch_i) begin
            next_pc_r  <= target_s;
            req_addr_r <= target_s;
            state_r    <= REQ;
          end else if (space_s) begin
            req_addr_r <= next_pc_r;
            state_r    <= REQ;
          end
        end
        REQ: begin
          if (rom_ack_i) begin
            if (branch_i) begin
              next_pc_r  <= target_s;
              req_addr_r <= target_s;
            end else begin
              next_pc_r <= req_addr_r + ADDR_W'(4);
              if (space_s) begin
                req_addr_r <= req_addr_r + ADDR_W'(4);
              end else begin
                state_r <= IDLE;
              end
            end
          end else if (branch_i) begin
            // rom_addr_o must stay put until the pending request is acknowledged.
            next_pc_r <= target_s;
            state_r   <= DROP;
          end
        end
        DROP: begin
          if (branch_i) begin
            next_pc_r <= target_s;
          end
          if (rom_ack_i) begin
            req_addr_r <= branch_i ? target_s : next_pc_r;
            state_r    <= REQ;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign rom_ce_o   = (state_r != IDLE);
  assign rom_addr_o = req_addr_r;
  assign id_valid_o = (count_r != '0);
  assign id_pc_o    = pc_q_r[rd_ptr_r];
  assign id_inst_o  = inst_q_r[rd_ptr_r];

endmodule

// File: tb/tb_if_fetch_queue.sv
// Bench for if_fetch_queue: a memory responder plus a stream scoreboard that tracks the
// PC sequence ID must observe, with directed scenarios and a randomized soak.
module tb_if_fetch_queue;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rom_ce, rom_ack = 1'b0, branch = 1'b0, id_valid, id_ready = 1'b0;
  logic [31:0] rom_addr, rom_data = 32'd0, branch_addr = 32'd0, id_pc, id_inst;
  logic        ce2, valid2;
  logic [31:0] addr2, pc2, inst2;

  int          errors = 0;
  int          checks = 0;
  int          ack_delay = 0;
  bit          ack_rand = 1'b0;
  int          pend = 0;
  bit          drv_done = 1'b0;
  logic [31:0] exp_pc = 32'd0;
  bit          hold_prev = 1'b0;
  logic [31:0] hold_addr = 32'd0;
  bit          br_prev = 1'b0;

  always #5 clk = ~clk;

  if_fetch_queue #(.ADDR_W(32), .INST_W(32), .DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .rom_ce_o(rom_ce), .rom_addr_o(rom_addr), .rom_ack_i(rom_ack),
    .rom_data_i(rom_data), .branch_i(branch), .branch_addr_i(branch_addr),
    .id_valid_o(id_valid), .id_pc_o(id_pc), .id_inst_o(id_inst), .id_ready_i(id_ready));

  if_fetch_queue #(.ADDR_W(32), .INST_W(32), .DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) dut_wrap (
    .clk(clk), .rst(rst), .rom_ce_o(ce2), .rom_addr_o(addr2), .rom_ack_i(rom_ack),
    .rom_data_i(~addr2), .branch_i(branch), .branch_addr_i(branch_addr),
    .id_valid_o(valid2), .id_pc_o(pc2), .id_inst_o(inst2), .id_ready_i(id_ready));

  // Memory model: answers with ~addr after ack_delay waiting cycles, or randomly.
  task automatic mem_drive();
    if (!drv_done) begin
      if (ack_rand) rom_ack = rom_ce && (($urandom % 2) == 1);
      else          rom_ack = rom_ce && (pend >= ack_delay);
      rom_data = ~rom_addr;
      drv_done = 1'b1;
    end
  endtask

  // Finish the current cycle: scoreboard, then advance to #1 after the next rising edge.
  task automatic step();
    mem_drive();
    if (hold_prev) begin
      checks++;
      if (rom_ce !== 1'b1 || rom_addr !== hold_addr) begin
        errors++;
        $display("FAIL addr_hold: ce=%b addr=%h, required ce=1 addr=%h", rom_ce, rom_addr, hold_addr);
      end
    end
    if (br_prev) begin
      checks++;
      if (id_valid !== 1'b0) begin
        errors++;
        $display("FAIL flush_valid: id_valid=%b, required 0", id_valid);
      end
    end
    if (rom_ce === 1'b1) begin
      checks++;
      if (rom_addr[1:0] !== 2'b00) begin
        errors++;
        $display("FAIL addr_align: addr=%h, required low bits 00", rom_addr);
      end
    end
    if (rst) begin
      exp_pc = 32'd0;
    end else if (branch) begin
      exp_pc = branch_addr & 32'hFFFF_FFFC;
    end else if (id_valid === 1'b1 && id_ready) begin
      checks++;
      if (id_pc !== exp_pc || id_inst !== ~exp_pc) begin
        errors++;
        $display("FAIL stream: pc=%h inst=%h, required pc=%h inst=%h", id_pc, id_inst, exp_pc, ~exp_pc);
      end
      exp_pc = exp_pc + 32'd4;
    end
    hold_prev = !rst && rom_ce && !rom_ack;
    hold_addr = rom_addr;
    br_prev   = !rst && branch;
    if (rst || !(rom_ce && !rom_ack)) pend = 0;
    else pend++;
    @(posedge clk);
    #1;
    drv_done = 1'b0;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    branch = 1'b0;
    repeat (n) step();
    rst = 1'b0;
  endtask

  task automatic test_reset_stream();
    ack_delay = 0; ack_rand = 1'b0; id_ready = 1'b1;
    do_reset(3);
    checks++;
    if (rom_ce !== 1'b0 || rom_addr !== 32'd0 || id_valid !== 1'b0 || id_pc !== 32'd0 ||
        id_inst !== 32'd0 || addr2 !== 32'hFFFF_FFF8) begin
      errors++;
      $display("FAIL reset_vals: ce=%b addr=%h v=%b pc=%h inst=%h addr2=%h, required 0,0,0,0,0,fffffff8",
               rom_ce, rom_addr, id_valid, id_pc, id_inst, addr2);
    end
    step();
    checks++;
    if (rom_ce !== 1'b1 || rom_addr !== 32'd0 || id_valid !== 1'b0) begin
      errors++;
      $display("FAIL first_req: ce=%b addr=%h v=%b, required ce=1 addr=0 v=0", rom_ce, rom_addr, id_valid);
    end
    for (int k = 0; k < 4; k++) begin
      step();
      checks++;
      if (id_valid !== 1'b1 || id_pc !== 32'(4 * k) || id_inst !== ~32'(4 * k)) begin
        errors++;
        $display("FAIL stream_cycle%0d: v=%b pc=%h, required v=1 pc=%h", k + 2, id_valid, id_pc, 32'(4 * k));
      end
    end
  endtask

  task automatic test_backpressure();
    int acks = 0;
    ack_delay = 0; id_ready = 1'b0;
    do_reset(2);
    for (int i = 0; i < 12; i++) begin
      mem_drive();
      if (rom_ce && rom_ack) acks++;
      step();
    end
    checks++;
    if (acks != 4 || rom_ce !== 1'b0 || id_valid !== 1'b1 || id_pc !== 32'd0) begin
      errors++;
      $display("FAIL full_queue: acks=%0d ce=%b v=%b pc=%h, required 4,0,1,0", acks, rom_ce, id_valid, id_pc);
    end
    id_ready = 1'b1;
    step();
    id_ready = 1'b0;
    checks++;
    if (rom_ce !== 1'b1 || rom_addr !== 32'h10 || id_pc !== 32'h4) begin
      errors++;
      $display("FAIL refill: ce=%b addr=%h pc=%h, required 1,10,4", rom_ce, rom_addr, id_pc);
    end
    id_ready = 1'b1;
    repeat (10) step();
  endtask

  task automatic test_flush();
    ack_delay = 0; id_ready = 1'b0;
    do_reset(2);
    repeat (4) step();
    branch = 1'b1; branch_addr = 32'h103;
    step();
    branch = 1'b0;
    checks++;
    if (id_valid !== 1'b0 || rom_ce !== 1'b1 || rom_addr !== 32'h100) begin
      errors++;
      $display("FAIL flush_redirect: v=%b ce=%b addr=%h, required 0,1,100", id_valid, rom_ce, rom_addr);
    end
    id_ready = 1'b1;
    step();
    checks++;
    if (id_valid !== 1'b1 || id_pc !== 32'h100 || id_inst !== ~32'h100) begin
      errors++;
      $display("FAIL flush_target: v=%b pc=%h, required v=1 pc=100", id_valid, id_pc);
    end
    repeat (6) step();
  endtask

  task automatic test_inflight();
    int n = 0;
    ack_delay = 3; id_ready = 1'b1;
    do_reset(2);
    while (!(rom_ce && rom_addr == 32'h8) && n < 40) begin step(); n++; end
    checks++;
    if (!(rom_ce && rom_addr == 32'h8)) begin
      errors++;
      $display("FAIL wait_addr8: addr=%h after %0d cycles, required 8", rom_addr, n);
    end
    branch = 1'b1; branch_addr = 32'h200;
    step();
    branch = 1'b0;
    checks++;
    if (id_valid !== 1'b0 || rom_ce !== 1'b1 || rom_addr !== 32'h8) begin
      errors++;
      $display("FAIL drop_hold: v=%b ce=%b addr=%h, required 0,1,8", id_valid, rom_ce, rom_addr);
    end
    n = 0;
    mem_drive();
    while (!rom_ack && n < 10) begin step(); mem_drive(); n++; end
    step();
    checks++;
    if (rom_ce !== 1'b1 || rom_addr !== 32'h200) begin
      errors++;
      $display("FAIL after_drop: ce=%b addr=%h, required 1,200", rom_ce, rom_addr);
    end
    n = 0;
    while (id_valid !== 1'b1 && n < 20) begin step(); n++; end
    checks++;
    if (id_valid !== 1'b1 || id_pc !== 32'h200) begin
      errors++;
      $display("FAIL inflight_target: v=%b pc=%h, required 1,200", id_valid, id_pc);
    end
    repeat (4) step();
  endtask

  task automatic test_double_redirect();
    int  n = 0;
    bit  saw300 = 1'b0;
    bit  got = 1'b0;
    ack_delay = 2; id_ready = 1'b1;
    do_reset(2);
    while (!(rom_ce && rom_addr == 32'h4) && n < 20) begin step(); n++; end
    branch = 1'b1; branch_addr = 32'h300;
    step();
    branch_addr = 32'h400;
    step();
    branch = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (rom_ce && rom_addr == 32'h300) saw300 = 1'b1;
      if (!got && id_valid === 1'b1) begin
        got = 1'b1;
        checks++;
        if (id_pc !== 32'h400) begin
          errors++;
          $display("FAIL double_target: pc=%h, required 400", id_pc);
        end
      end
      step();
    end
    checks++;
    if (saw300 || !got) begin
      errors++;
      $display("FAIL double_fetch: saw300=%b got=%b, required 0,1", saw300, got);
    end
  endtask

  task automatic test_reset_midreq();
    ack_delay = 3; id_ready = 1'b1;
    do_reset(2);
    repeat (2) step();
    rst = 1'b1;
    step();
    checks++;
    if (rom_ce !== 1'b0 || rom_addr !== 32'd0 || id_valid !== 1'b0 || id_pc !== 32'd0 || id_inst !== 32'd0) begin
      errors++;
      $display("FAIL midreq_reset: ce=%b addr=%h v=%b pc=%h inst=%h, required all 0",
               rom_ce, rom_addr, id_valid, id_pc, id_inst);
    end
    rst = 1'b0;
    step();
    checks++;
    if (rom_ce !== 1'b1 || rom_addr !== 32'd0) begin
      errors++;
      $display("FAIL restart: ce=%b addr=%h, required 1,0", rom_ce, rom_addr);
    end
    repeat (6) step();
  endtask

  task automatic test_wrap();
    logic [31:0] want;
    ack_delay = 0; id_ready = 1'b1;
    do_reset(2);
    step();
    for (int k = 0; k < 3; k++) begin
      step();
      want = 32'hFFFF_FFF8 + 32'(4 * k);
      checks++;
      if (valid2 !== 1'b1 || pc2 !== want || inst2 !== ~want) begin
        errors++;
        $display("FAIL wrap%0d: v=%b pc=%h, required v=1 pc=%h", k, valid2, pc2, want);
      end
    end
  endtask

  task automatic test_random();
    ack_rand = 1'b1;
    do_reset(2);
    for (int i = 0; i < 1500; i++) begin
      id_ready    = ($urandom % 4) != 0;
      branch      = ($urandom % 16) == 0;
      branch_addr = $urandom;
      step();
    end
    branch = 1'b0;
    ack_rand = 1'b0;
  endtask

  initial begin
    test_reset_stream();
    test_backpressure();
    test_flush();
    test_inflight();
    test_double_redirect();
    test_reset_midreq();
    test_wrap();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
